// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART serial receiver.
// Contents: rx FSM state enum, oversampling/frame constants, sample-tick indices,
//           and a 2-of-3 majority helper used when SPART_RX_MAJORITY_EN is defined.
package spart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  // Tick-counter values (0-based, i.e. value N is the (N+1)th tick) at which
  // a bit is decided. The start bit is taken mid-bit; every later bit is
  // taken one full bit period after the previous centre sample.
  localparam logic [3:0] START_TICK     = 4'd7;                   // 8th tick
  localparam logic [3:0] BIT_TICK       = 4'(OVERSAMPLE - 1);     // 16th tick
  // With majority voting the start decision moves to the 9th tick (samples
  // at ticks 7, 8, 9); later bits keep their decision on BIT_TICK with the
  // samples on the two preceding ticks, so the bit spacing stays 16 ticks.
  localparam logic [3:0] START_TICK_MAJ = START_TICK + 4'd1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/spart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to 1 (line idle).
// Latency: 2 clk from d_i to q_o. No backpressure.
// Ports: clk, rst (async, active-high), d_i (async input), q_o (synchronized output).
module spart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: 16x-oversampled 8N1 deserializer with sticky framing/overrun flags.
// Latency: outputs update on the stop-bit sample clock (2 clk synchronizer delay on rxd).
// Backpressure: none; a byte completing while rda is still set overwrites rx_data and sets overrun.
// Ports: clk, rst (async active-high), rx_baud_en (16x tick), rxd (serial line), rd (read strobe)
//        -> rx_data[7:0], rda, frame_err, overrun, rx_busy.
// Build option: define SPART_RX_MAJORITY_EN for 2-of-3 majority sampling of every bit.
module spart_rx
  import spart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_baud_en,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  logic rxd_s;

  spart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rxd),
    .q_o (rxd_s)
  );

  rx_state_e  state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rda_q, rda_d;
  logic       fe_q, fe_d;
  logic       ov_q, ov_d;

  logic       sample_now;
  logic       sample_bit;

`ifdef SPART_RX_MAJORITY_EN
  // History of the line at the last two baud ticks; combined with the
  // current sample it gives the three votes at the decision tick.
  logic [1:0] vote_q, vote_d;

  always_comb begin
    vote_d = vote_q;
    if (rx_baud_en) begin
      vote_d = {vote_q[0], rxd_s};
    end
  end

  assign sample_now = rx_baud_en &&
                      (tick_q == ((state_q == RX_START) ? START_TICK_MAJ : BIT_TICK));
  assign sample_bit = maj3(vote_q[1], vote_q[0], rxd_s);
`else
  assign sample_now = rx_baud_en &&
                      (tick_q == ((state_q == RX_START) ? START_TICK : BIT_TICK));
  assign sample_bit = rxd_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      rda_q     <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
`ifdef SPART_RX_MAJORITY_EN
      vote_q    <= 2'b11;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rda_q     <= rda_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
`ifdef SPART_RX_MAJORITY_EN
      vote_q    <= vote_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    // A read acknowledges the byte and clears the sticky flags; a byte
    // completion or framing error in the same cycle overrides below.
    rda_d     = rd ? 1'b0 : rda_q;
    fe_d      = rd ? 1'b0 : fe_q;
    ov_d      = rd ? 1'b0 : ov_q;

    if (rx_baud_en && (state_q == RX_START || state_q == RX_DATA || state_q == RX_STOP)) begin
      tick_d = tick_q + 4'd1;
    end

    case (state_q)
      RX_IDLE: begin
        if (!rxd_s) begin
          state_d = RX_START;
          tick_d  = '0;
        end
      end

      RX_START: begin
        if (sample_now) begin
          tick_d = '0;
          bit_d  = '0;
          // A start bit that reads high again was a glitch: drop it silently.
          state_d = sample_bit ? RX_IDLE : RX_DATA;
        end
      end

      RX_DATA: begin
        if (sample_now) begin
          tick_d  = '0;
          shift_d = {sample_bit, shift_q[7:1]};
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      RX_STOP: begin
        if (sample_now) begin
          tick_d = '0;
          if (sample_bit) begin
            rx_data_d = shift_q;
            rda_d     = 1'b1;
            if (rda_q && !rd) begin
              ov_d = 1'b1;
            end
            state_d = RX_IDLE;
          end else begin
            // Bad stop bit: keep the previous byte, wait for the line to idle
            // so a held-low break is not mistaken for a new start bit.
            fe_d    = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end
      end

      RX_WAIT_HIGH: begin
        if (rxd_s) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rda       = rda_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
  assign rx_busy   = (state_q != RX_IDLE);

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: table of back-to-back frames plus hand-written corner sequences.
// Frames are driven one line value per clk (16 clk per bit unless slowed baud ticks are used).
// Outputs are sampled 1 time unit after the rising edge.
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_baud_en;
  logic       rxd;
  logic       rd;
  logic [7:0] rx_data;
  logic       rda;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  always #5 clk = ~clk;

  spart_rx dut (
    .clk        (clk),
    .rst        (rst),
    .rx_baud_en (rx_baud_en),
    .rxd        (rxd),
    .rd         (rd),
    .rx_data    (rx_data),
    .rda        (rda),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .rx_busy    (rx_busy)
  );

  // Edge (counted from the first low line sample) on which the stop bit is decided.
`ifdef SPART_RX_MAJORITY_EN
  localparam int         DONE_EDGE  = 155;
  localparam logic [7:0] GLITCH_EXP = 8'hFF;
`else
  localparam int         DONE_EDGE  = 154;
  localparam logic [7:0] GLITCH_EXP = 8'hF7;
`endif

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] data;
    int         glitch;   // cycle index of a 1-clk low glitch, -1 for none
    int         rd_mode;  // 0 none, 1 rd pulse before frame, 2 rd on the completion edge
    logic       e_rda;
    logic [7:0] e_data;
    logic       e_fe;
    logic       e_ov;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    return stop;
  endfunction

  // Drives one 10-bit frame, cpb clk per bit. cpb=32 pairs with a baud tick every other clk.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch,
                            input int rd_at, input int cpb);
    for (int i = 0; i < 10 * cpb; i++) begin
      rxd = (i == glitch) ? 1'b0 : frame_bit(d, stop, i / cpb);
      rd  = (i == rd_at);
      rx_baud_en = (cpb == 16) ? 1'b1 : (i % 2 == 0);
      cyc(1);
    end
    rd = 1'b0;
    rx_baud_en = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic e_rda, input logic [7:0] e_data,
                           input logic e_fe, input logic e_ov, input logic e_busy);
    chk({tag, ".rda"}, rda, e_rda);
    chk({tag, ".rx_data"}, rx_data, e_data);
    chk({tag, ".frame_err"}, frame_err, e_fe);
    chk({tag, ".overrun"}, overrun, e_ov);
    chk({tag, ".rx_busy"}, rx_busy, e_busy);
  endtask

  initial begin
    vecs[0] = '{8'hA5, -1, 0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h11, -1, 1, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[2] = '{8'h22, -1, 0, 1'b1, 8'h22, 1'b0, 1'b1};
    vecs[3] = '{8'h00, -1, 1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 72, 1, 1'b1, GLITCH_EXP, 1'b0, 1'b0};
    vecs[5] = '{8'h80, -1, 0, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h3C, -1, 2, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[7] = '{8'h01, -1, 1, 1'b1, 8'h01, 1'b0, 1'b0};

    rst = 1'b1;
    rxd = 1'b1;
    rd = 1'b0;
    rx_baud_en = 1'b1;
    cyc(3);
    check_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(4);

    // Table of frames, each with a valid stop bit.
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].rd_mode == 1) pulse_rd();
      send_frame(vecs[v].data, 1'b1, vecs[v].glitch,
                 (vecs[v].rd_mode == 2) ? DONE_EDGE : -1, 16);
      cyc(4);
      check_out($sformatf("vec%0d", v), vecs[v].e_rda, vecs[v].e_data,
                vecs[v].e_fe, vecs[v].e_ov, 1'b0);
    end

    // Two frames without a read, then a read clears rda and overrun.
    pulse_rd();
    send_frame(8'h11, 1'b1, -1, -1, 16);
    cyc(2);
    send_frame(8'h22, 1'b1, -1, -1, 16);
    cyc(4);
    check_out("ovr", 1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    pulse_rd();
    check_out("ovr_rd", 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);

    // Short low pulse on the line: start-bit glitch rejection.
    rxd = 1'b0;
    cyc(3);
    rxd = 1'b1;
    cyc(2);
    chk("glitch.busy_mid", rx_busy, 1'b1);
    cyc(20);
    check_out("glitch", 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);

    // Framing error: stop bit low, line held low afterwards.
    send_frame(8'h3C, 1'b0, -1, -1, 16);
    cyc(20);
    check_out("ferr", 1'b0, 8'h22, 1'b1, 1'b0, 1'b1);
    rxd = 1'b1;
    cyc(4);
    chk("ferr.busy_after_high", rx_busy, 1'b0);
    pulse_rd();
    check_out("ferr_rd", 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);

    // Baud ticks only every other clk: bit period 32 clk.
    send_frame(8'hC3, 1'b1, -1, -1, 32);
    cyc(4);
    check_out("slow", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);

    // Reset during bit 4 of a frame, then a clean frame.
    for (int i = 0; i < 88; i++) begin
      rxd = frame_bit(8'h5A, 1'b1, i / 16);
      cyc(1);
    end
    chk("rst.busy_before", rx_busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_out("rst_mid", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1);
    rst = 1'b0;
    rxd = 1'b1;
    cyc(20);
    send_frame(8'h5A, 1'b1, -1, -1, 16);
    cyc(4);
    check_out("post_rst", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
